cmd_frame_decoder: RTL and testbench
====================================

# cmd_frame_decoder

Parametrised successor to the robot command decoder. It sits between the UART receiver and the motor/kicker drivers. It parses sync-delimited command frames carrying N motor bytes, one kicker byte and an optional checksum. Outputs update atomically only on a complete, valid frame. It adds a per-byte gap timeout, a link-loss watchdog that forces failsafe outputs, and a saturating frame-error counter.

## Interface
- NUM_MOTORS, 4, number of motor command bytes per frame (1–8)
- SYNC_BYTE, 8'hFF, frame start marker
- BYTE_GAP_CYCLES, 50000, maximum idle cycles between bytes inside a frame
- TIMEOUT_CYCLES, 5000000, cycles without a committed frame before failsafe
- clk  input  1  system clock; all logic is on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- data  input  8  received byte
- receive_flag  input  1  one-cycle strobe; data is valid in that cycle
- motor_cmd  output  8*NUM_MOTORS  motor k occupies bits [8k+7:8k]
- kick_charge  output  7  kicker byte bits [6:0]
- dribbler  output  1  kicker byte bit 7
- charge_flag  output  1  high when committed kick_charge != 0
- frame_valid  output  1  one-cycle pulse per committed frame
- failsafe  output  1  high while the watchdog has expired
- err_count  output  8  saturating count of rejected frames

## Operation
- Frame layout: SYNC_BYTE, motor[0..NUM_MOTORS-1], kicker, then checksum (checksum only when CHECKSUM_EN is defined).
- FSM states:
  - HUNT: on a strobe with data == SYNC_BYTE, go to PAYLOAD and clear the byte index and running sum. Any other byte is discarded silently and is not counted as an error.
  - PAYLOAD: each strobe writes data into shadow register[idx], adds it to the running sum (mod 256) and increments idx. A SYNC_BYTE value inside the payload is treated as ordinary data. On the kicker byte, go to CHECK if CHECKSUM_EN is defined; otherwise commit and return to HUNT.
  - CHECK: on the next strobe, if data == running sum, commit. Otherwise increment err_count. Return to HUNT in either case.
- Commit: shadow registers are copied to motor_cmd, kick_charge and dribbler. charge_flag is set to (kicker[6:0] != 0) from the same value. frame_valid pulses, failsafe clears and the watchdog is reset.
- Gap timeout: in PAYLOAD/CHECK, a gap counter increments each cycle without a strobe and is cleared on every strobe. When it reaches BYTE_GAP_CYCLES-1, the FSM aborts to HUNT and err_count increments. Shadow contents are discarded and outputs are unchanged.
- Watchdog: counts cycles since the last commit (or since reset). When it reaches TIMEOUT_CYCLES-1:
  - motor_cmd, kick_charge, dribbler and charge_flag are forced to 0 and failsafe is set.
  - The counter holds (no wrap) until the next commit.
- err_count saturates at 255 and clears only on reset.

## Timing
- Reset values: all outputs are 0. The FSM is in HUNT and all counters are 0.
- Latency: outputs and frame_valid change at the same rising edge that samples the final byte of the frame (the kicker byte, or the checksum byte when CHECKSUM_EN is defined). They are visible in the following cycle.
- receive_flag strobes may arrive on consecutive cycles. Every strobe is accepted; there is no backpressure.
- Simultaneous commit and watchdog expiry in the same cycle: the commit wins and failsafe stays 0.
- Simultaneous gap-timeout expiry and a strobe in the same cycle: the strobe wins, the byte is accepted and the gap counter clears.
- reset_n asserted mid-frame: immediate return to HUNT and all outputs are 0, regardless of clk.
- Counter widths are $clog2 of the respective parameter. The byte index is $clog2(NUM_MOTORS+2) bits.

## Configuration
- CHECKSUM_EN defined:
  - Frames carry a trailing checksum byte equal to the 8-bit modular sum of the motor and kicker bytes.
  - A mismatch rejects the frame and increments err_count.
- CHECKSUM_EN undefined:
  - There is no CHECK state; the frame commits on the kicker byte.
  - err_count increments only on gap timeouts.

## Test plan
- Valid frame (NUM_MOTORS=4, CHECKSUM_EN defined): FF 10 20 30 40 85 25 -> motor_cmd=32'h40302010, kick_charge=7'h05, dribbler=1, charge_flag=1, one frame_valid pulse.
- Bad checksum: FF 10 20 30 40 85 26 -> outputs unchanged, err_count=1, no frame_valid pulse.
- Garbage then frame: 12 34 FF 01 02 03 04 00 0A -> leading bytes ignored, motor_cmd=32'h04030201, charge_flag=0, err_count=0.
- Gap timeout with BYTE_GAP_CYCLES=8: FF 10, 8 idle cycles, then 20 -> abort to HUNT, err_count=1. The 20 is discarded while hunting.
- Watchdog with TIMEOUT_CYCLES=100: after a valid frame, 100 cycles without strobes -> all outputs 0 and failsafe=1. The next valid frame clears failsafe and restores its values.
- reset_n pulsed low after FF 10 20 -> outputs 0. A following complete frame decodes correctly.

Source files
------------

// File: rtl/cmd_frame_decoder.sv
// Sync-delimited command frame decoder with byte-gap timeout, link-loss watchdog and error counter.
// Define CHECKSUM_EN to require a trailing 8-bit modular checksum byte on every frame.
module cmd_frame_decoder #(
  parameter int         NUM_MOTORS      = 4,
  parameter logic [7:0] SYNC_BYTE       = 8'hFF,
  parameter int         BYTE_GAP_CYCLES = 50000,
  parameter int         TIMEOUT_CYCLES  = 5000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                data,
  input  logic                      receive_flag,
  output logic [8*NUM_MOTORS-1:0]   motor_cmd,
  output logic [6:0]                kick_charge,
  output logic                      dribbler,
  output logic                      charge_flag,
  output logic                      frame_valid,
  output logic                      failsafe,
  output logic [7:0]                err_count
);

  localparam int IW = $clog2(NUM_MOTORS + 2);
  localparam int GW = (BYTE_GAP_CYCLES > 1) ? $clog2(BYTE_GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = 8 * (NUM_MOTORS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MOTORS);
  localparam logic [GW-1:0] GAP_MAX  = GW'(BYTE_GAP_CYCLES - 1);
  localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT_CYCLES - 1);

`ifdef CHECKSUM_EN
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1, CHECK = 2'd2} state_e;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, PAYLOAD = 2'd1} state_e;
`endif

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [7:0]              sum_q, sum_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [TW-1:0]           wd_q, wd_d;
  logic [SW-1:0]           shadow_q, shadow_d;
  logic [8*NUM_MOTORS-1:0] motor_q, motor_d;
  logic [6:0]              kick_q, kick_d;
  logic                    drib_q, drib_d;
  logic                    charge_q, charge_d;
  logic                    fv_q, fv_d;
  logic                    fs_q, fs_d;
  logic [7:0]              err_q, err_d;
  logic                    in_frame_s, gap_abort_s, commit_s, reject_s;
  logic [7:0]              kicker_s;

  // Inter-byte gap counter; a strobe always beats an expiring gap.
  always_comb begin
    in_frame_s  = (state_q != HUNT);
    gap_abort_s = in_frame_s && !receive_flag && (gap_q == GAP_MAX);
    if (!in_frame_s || receive_flag || gap_abort_s) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GW'(1);
    end
  end

  // Frame parser: next state, shadow capture, running sum, commit/reject decisions.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    shadow_d = shadow_q;
    commit_s = 1'b0;
    reject_s = 1'b0;
    case (state_q)
      HUNT: begin
        if (receive_flag && (data == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          sum_d   = 8'h00;
        end else begin
          state_d = HUNT;
        end
      end
      PAYLOAD: begin
        if (receive_flag) begin
          for (int k = 0; k <= NUM_MOTORS; k++) begin
            if (idx_q == IW'(k)) begin
              shadow_d[8*k +: 8] = data;
            end else begin
              shadow_d[8*k +: 8] = shadow_q[8*k +: 8];
            end
          end
          sum_d = sum_q + data;
          idx_d = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
`ifdef CHECKSUM_EN
            state_d = CHECK;
`else
            commit_s = 1'b1;
            state_d  = HUNT;
`endif
          end else begin
            state_d = PAYLOAD;
          end
        end else if (gap_abort_s) begin
          state_d  = HUNT;
          reject_s = 1'b1;
        end else begin
          state_d = PAYLOAD;
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (receive_flag) begin
          state_d = HUNT;
          if (data == sum_q) begin
            commit_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end else if (gap_abort_s) begin
          state_d  = HUNT;
          reject_s = 1'b1;
        end else begin
          state_d = CHECK;
        end
      end
`endif
      default: state_d = HUNT;
    endcase
  end

  // Output staging: commit beats watchdog expiry, expiry forces safe outputs.
  always_comb begin
    kicker_s = shadow_d[SW-1 -: 8];
    motor_d  = motor_q;
    kick_d   = kick_q;
    drib_d   = drib_q;
    charge_d = charge_q;
    fs_d     = fs_q;
    fv_d     = commit_s;
    if (wd_q == WD_MAX) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + TW'(1);
    end
    if (commit_s) begin
      wd_d     = '0;
      fs_d     = 1'b0;
      motor_d  = shadow_d[8*NUM_MOTORS-1:0];
      kick_d   = kicker_s[6:0];
      drib_d   = kicker_s[7];
      charge_d = (kicker_s[6:0] != 7'd0);
    end else if (wd_d == WD_MAX) begin
      fs_d     = 1'b1;
      motor_d  = '0;
      kick_d   = 7'd0;
      drib_d   = 1'b0;
      charge_d = 1'b0;
    end else begin
      fs_d = fs_q;
    end
    if (reject_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      sum_q    <= 8'h00;
      gap_q    <= '0;
      wd_q     <= '0;
      shadow_q <= '0;
      motor_q  <= '0;
      kick_q   <= 7'd0;
      drib_q   <= 1'b0;
      charge_q <= 1'b0;
      fv_q     <= 1'b0;
      fs_q     <= 1'b0;
      err_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      gap_q    <= gap_d;
      wd_q     <= wd_d;
      shadow_q <= shadow_d;
      motor_q  <= motor_d;
      kick_q   <= kick_d;
      drib_q   <= drib_d;
      charge_q <= charge_d;
      fv_q     <= fv_d;
      fs_q     <= fs_d;
      err_q    <= err_d;
    end
  end

  assign motor_cmd   = motor_q;
  assign kick_charge = kick_q;
  assign dribbler    = drib_q;
  assign charge_flag = charge_q;
  assign frame_valid = fv_q;
  assign failsafe    = fs_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Directed bench for cmd_frame_decoder: frame-level reference model compared every cycle plus literal expectations.
module tb_cmd_frame_decoder;
  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int T   = 100;
`ifdef CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  typedef logic [7:0] frm_t [6];

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          receive_flag = 1'b0;
  logic [31:0]   motor_cmd;
  logic [6:0]    kick_charge;
  logic          dribbler, charge_flag, frame_valid, failsafe;
  logic [7:0]    err_count;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // reference model state
  logic [31:0] m_motor;
  logic [6:0]  m_kick;
  logic        m_drib, m_charge, m_fv, m_fs;
  logic [7:0]  m_err;
  bit          m_hunt;
  int          m_idle, m_since;
  logic [7:0]  m_buf[$];

  always #5 clk = ~clk;

  cmd_frame_decoder #(
    .NUM_MOTORS(N), .SYNC_BYTE(8'hFF), .BYTE_GAP_CYCLES(GAP), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .receive_flag(receive_flag),
    .motor_cmd(motor_cmd), .kick_charge(kick_charge), .dribbler(dribbler),
    .charge_flag(charge_flag), .frame_valid(frame_valid), .failsafe(failsafe),
    .err_count(err_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_motor = 32'h0; m_kick = 7'h0; m_drib = 1'b0; m_charge = 1'b0;
    m_fv = 1'b0; m_fs = 1'b0; m_err = 8'h00;
    m_hunt = 1'b1; m_idle = 0; m_since = 0;
    m_buf.delete();
  endtask

  task automatic m_step();
    logic [7:0] s;
    bit committed;
    committed = 1'b0;
    m_fv = 1'b0;
    if (receive_flag) begin
      m_idle = 0;
      if (m_hunt) begin
        if (data == 8'hFF) begin
          m_hunt = 1'b0;
          m_buf.delete();
        end
      end else begin
        m_buf.push_back(data);
        if (m_buf.size() == N + 1 + CK) begin
          m_hunt = 1'b1;
          s = 8'h00;
          for (int k = 0; k <= N; k++) s = s + m_buf[k];
          if (CK == 0 || m_buf[N+1] == s) committed = 1'b1;
          else if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end
    end else if (!m_hunt) begin
      m_idle++;
      if (m_idle == GAP) begin
        m_hunt = 1'b1;
        m_idle = 0;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
    end
    if (committed) begin
      for (int k = 0; k < N; k++) m_motor[8*k +: 8] = m_buf[k];
      m_kick   = m_buf[N][6:0];
      m_drib   = m_buf[N][7];
      m_charge = (m_buf[N][6:0] != 7'h0);
      m_fv     = 1'b1;
      m_fs     = 1'b0;
      m_since  = 0;
    end else begin
      if (m_since < T - 1) m_since++;
      if (m_since == T - 1) begin
        m_fs = 1'b1; m_motor = 32'h0; m_kick = 7'h0; m_drib = 1'b0; m_charge = 1'b0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("motor_cmd", motor_cmd, m_motor);
        chk("kick_charge", kick_charge, m_kick);
        chk("dribbler", dribbler, m_drib);
        chk("charge_flag", charge_flag, m_charge);
        chk("frame_valid", frame_valid, m_fv);
        chk("failsafe", failsafe, m_fs);
        chk("err_count", err_count, m_err);
      end
    end
  end

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    receive_flag = 1'b1;
    data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      receive_flag = 1'b0;
    end
  endtask

  task automatic send(input frm_t f, input logic [7:0] ck);
    for (int k = 0; k < 6; k++) put(f[k]);
    if (CK != 0) put(ck);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    idle(3);
    chk("reset_motor", motor_cmd, 32'h0);
    chk("reset_failsafe", failsafe, 1'b0);
    chk("reset_err", err_count, 8'h00);
    chk("reset_fv", frame_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    check_en = 1'b1;

    send('{8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h85}, 8'h25);
    chk("valid_motor", motor_cmd, 32'h40302010);
    chk("valid_kick", kick_charge, 7'h05);
    chk("valid_drib", dribbler, 1'b1);
    chk("valid_charge", charge_flag, 1'b1);
    chk("valid_fv", frame_valid, 1'b1);
    idle(1);
    chk("valid_fv_pulse", frame_valid, 1'b0);

`ifdef CHECKSUM_EN
    send('{8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h85}, 8'h26);
    chk("badck_fv", frame_valid, 1'b0);
    chk("badck_err", err_count, 8'h01);
    chk("badck_motor", motor_cmd, 32'h40302010);
`endif

    put(8'h12);
    put(8'h34);
    send('{8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00}, 8'h0A);
    chk("garbage_motor", motor_cmd, 32'h04030201);
    chk("garbage_charge", charge_flag, 1'b0);
    chk("garbage_err", err_count, 8'(CK));

    put(8'hFF);
    put(8'h10);
    idle(GAP);
    put(8'h20);
    idle(2);
    chk("gap_err", err_count, 8'(CK + 1));
    chk("gap_motor", motor_cmd, 32'h04030201);

    put(8'hFF);
    put(8'h10);
    idle(GAP - 1);
    put(8'h20);
    put(8'h30);
    put(8'h40);
    put(8'h85);
    if (CK != 0) put(8'h25);
    idle(1);
    chk("gap_edge_fv", frame_valid, 1'b1);
    chk("gap_edge_motor", motor_cmd, 32'h40302010);
    chk("gap_edge_err", err_count, 8'(CK + 1));

    idle(T - 2);
    chk("wd_before_fs", failsafe, 1'b0);
    chk("wd_before_motor", motor_cmd, 32'h40302010);
    idle(1);
    chk("wd_fs", failsafe, 1'b1);
    chk("wd_motor", motor_cmd, 32'h0);
    chk("wd_kick", kick_charge, 7'h0);
    chk("wd_drib", dribbler, 1'b0);
    chk("wd_charge", charge_flag, 1'b0);
    idle(20);
    chk("wd_hold_fs", failsafe, 1'b1);
    send('{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03}, 8'hAD);
    chk("wd_clear_fs", failsafe, 1'b0);
    chk("wd_restore_motor", motor_cmd, 32'h44332211);
    chk("wd_restore_kick", kick_charge, 7'h03);
    chk("wd_restore_charge", charge_flag, 1'b1);

    put(8'hFF);
    put(8'h10);
    put(8'h20);
    @(posedge clk);
    #2;
    check_en = 1'b0;
    receive_flag = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_async_motor", motor_cmd, 32'h0);
    chk("rst_async_charge", charge_flag, 1'b0);
    chk("rst_async_err", err_count, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_en = 1'b1;
    send('{8'hFF, 8'h10, 8'h20, 8'h30, 8'h40, 8'h85}, 8'h25);
    chk("rst_after_motor", motor_cmd, 32'h40302010);
    chk("rst_after_fv", frame_valid, 1'b1);
    chk("rst_after_err", err_count, 8'h00);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
